dmem_sized_ctrl: RTL and testbench
==================================

Name: dmem_sized_ctrl

Overview:
- Parametrised data-memory controller for the single-cycle/multicycle CPU datapath; successor of the fixed 32x32 data memory.
- Adds:
  - configurable width, depth and wait states;
  - valid/ready request handshake;
  - byte/half/word(/dword) load-store with sign or zero extension;
  - alignment error reporting.
- Sits between the datapath's memory stage and the word array; one outstanding request at a time.

Parameters:
- DATA_WIDTH, 32, word width in bits; legal values 32 or 64.
- DEPTH, 32, number of words; power of two, at least 2.
- WAIT_STATES, 0, extra cycles between request accept and response; 0..15.
- Derived (localparam, not overridable):
  - OFS = log2(DATA_WIDTH/8), byte-offset bits;
  - IDX = log2(DEPTH), word-index bits.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- mem_write  in  1  1 = store, 0 = load.
- mem_size  in  2  access size: 00 byte, 01 half, 10 word(32), 11 dword(64, DATA_WIDTH=64 only).
- mem_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored on stores.
- address  in  32  byte address.
- write_data  in  DATA_WIDTH  store data, right-aligned (LSBs used).
- resp_valid  out  1  one-cycle pulse: access completed.
- read_data  out  DATA_WIDTH  extended load result; holds its value until the next load response.
- resp_error  out  1  qualified by resp_valid: misaligned or illegal-size access.

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, read_data=0, resp_error=0, wait counter=0.
  - Memory array is not cleared by reset; simulation power-up contents are 0.
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture address/op/size/unsigned/write_data; go to WAIT if WAIT_STATES>0, else ACCESS.
  - WAIT: req_ready=0; load counter with WAIT_STATES-1, decrement each cycle; at 0 go to ACCESS.
  - ACCESS: req_ready=0; perform the access on the captured request; go to IDLE.
  - Response is registered: resp_valid=1 in the cycle after ACCESS, coinciding with IDLE.
- Latency: request accepted at edge N -> resp_valid high during cycle N+2+WAIT_STATES. Back-to-back throughput is one request per 2+WAIT_STATES cycles.
  - A new request may be accepted in the same cycle resp_valid is high.
- Indexing:
  - word index = address[OFS+IDX-1:OFS]; byte lane = address[OFS-1:0].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH*DATA_WIDTH/8.
- Stores:
  - Write only the addressed lanes (byte: 1 lane, half: 2, word: 4, dword: all).
  - Lanes are taken from write_data LSBs, shifted to the lane offset.
  - Unaddressed lanes are preserved.
- Loads:
  - Extract the addressed lanes, right-align, and extend to DATA_WIDTH per mem_unsigned.
  - Word load on DATA_WIDTH=64 extends bit 31.
  - Loads do not disturb the array.
- Store response: resp_valid pulses; read_data unchanged.
- Errors: mem_size=11 with DATA_WIDTH=32 is an illegal size.
- Reset during WAIT/ACCESS: request dropped, no write performed, no response issued; next cycle IDLE.
- req_valid deasserted while req_ready=0: no effect; inputs are sampled only at accept.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned access (half on odd address, word not 4-aligned, dword not 8-aligned) or illegal size completes normally in timing.
  - resp_error=1, no write performed, read_data unchanged.
- Not defined:
  - Low offset bits are masked down to the natural alignment of the size (half: bit0 cleared; word: bits[1:0] cleared).
  - resp_error is tied to 0 except for an illegal size, which is forced to word.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - FSM state enum;
  - function computing lane mask from size and offset.
- One natural sub-module, dmem_lane_align: combinational.
  - Store path: produce lane-shifted write data and byte mask.
  - Load path: extract and extend read data.
  - Instantiated once.

Test Plan:
- Reset, then word store 0xDEADBEEF @0x8, then unsigned word load @0x8 -> resp_valid exactly 2 cycles after each accept; read_data=0xDEADBEEF.
- Byte store 0x80 @0x9 over 0xDEADBEEF, then signed byte load @0x9 -> 0xFFFFFF80; unsigned byte load @0x9 -> 0x00000080; word load @0x8 -> 0xDEAD80EF.
- WAIT_STATES=3, half store 0x1234 @0x2, then signed half load @0x2 -> response 5 cycles after accept; req_ready=0 throughout; read_data=0x00001234.
- With DMEM_ALIGN_CHECK_EN defined, word load @0x6 -> resp_error=1, read_data unchanged. Without the macro, same load returns word @0x4, resp_error=0.
- DEPTH=32, word store 0x11 @0x80 (wraps) then word load @0x0 -> 0x00000011.
- Reset asserted during WAIT of a store 0xFF @0x0 -> no resp_valid; subsequent load @0x0 returns the prior value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data-memory controller: access-size
// encodings, the controller FSM state type and lane/alignment helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } dmem_state_t;

  // Byte-lane enable for an access of the given size starting at lane ofs.
  function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                           input logic [2:0] ofs);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << ofs;
  endfunction

  // Offset rounded down to the natural alignment of the access size.
  function automatic logic [2:0] align_ofs(input logic [1:0] size,
                                           input logic [2:0] ofs);
    case (size)
      SZ_HALF:  return {ofs[2:1], 1'b0};
      SZ_WORD:  return {ofs[2], 2'b00};
      SZ_DWORD: return 3'b000;
      default:  return ofs;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: shifts store data onto the addressed byte
// lanes with a matching byte mask, and right-aligns plus sign/zero extends
// load data taken from the addressed lanes of a memory word.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]                      i_size,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] i_ofs,
  input  logic                            i_unsigned,
  input  logic [DATA_WIDTH-1:0]           i_wdata,
  input  logic [DATA_WIDTH-1:0]           i_rword,
  output logic [DATA_WIDTH-1:0]           o_wdata_sh,
  output logic [DATA_WIDTH/8-1:0]         o_be,
  output logic [DATA_WIDTH-1:0]           o_rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [7:0]            w_mask8;
  logic [DATA_WIDTH-1:0] w_rsh;
  logic [DATA_WIDTH-1:0] w_keep;
  logic                  w_msb;
  logic                  w_sign;

  // Store path: move right-aligned data to its lanes and enable those lanes.
  always_comb begin
    w_mask8    = lane_mask(i_size, 3'(i_ofs));
    o_be       = w_mask8[NB-1:0];
    o_wdata_sh = i_wdata << {i_ofs, 3'b000};
  end

  // Load path: right-align the addressed lanes and extend above the size.
  always_comb begin
    w_rsh = i_rword >> {i_ofs, 3'b000};
    case (i_size)
      SZ_BYTE: begin
        w_keep = DATA_WIDTH'(64'h0000_0000_0000_00FF);
        w_msb  = w_rsh[7];
      end
      SZ_HALF: begin
        w_keep = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
        w_msb  = w_rsh[15];
      end
      SZ_WORD: begin
        w_keep = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
        w_msb  = w_rsh[31];
      end
      default: begin
        w_keep = '1;
        w_msb  = w_rsh[DATA_WIDTH-1];
      end
    endcase
    w_sign  = ~i_unsigned & w_msb;
    o_rdata = (w_rsh & w_keep) | ({DATA_WIDTH{w_sign}} & ~w_keep);
  end

endmodule

// File: rtl/dmem_sized_ctrl.sv
// Sized data-memory controller: one outstanding request, optional wait
// states, byte/half/word(/dword) loads and stores with extension.
// Build option DMEM_ALIGN_CHECK_EN: when defined, misaligned or illegal-size
// accesses complete with resp_error=1 and no side effects; when undefined,
// offsets are rounded down to natural alignment and an illegal size is
// treated as a word access.
module dmem_sized_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  resp_error
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam int IDX = $clog2(DEPTH);
  localparam int AW  = OFS + IDX;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  dmem_state_t           r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  w_accept;
  logic                  w_do_access;

  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_illegal;
  logic [1:0]            w_size_eff;
  logic [2:0]            w_ofs_raw;
  logic [2:0]            w_ofs3;
  logic                  w_err;
  logic [IDX-1:0]        w_idx;
  logic [DATA_WIDTH-1:0] w_wdata_sh;
  logic [NB-1:0]         w_be;
  logic [DATA_WIDTH-1:0] w_rdata_ext;
  logic                  w_unused;

  // Upper address bits only select aliases of the same word.
  assign w_unused = ^{address[31:AW], w_ofs3};

  // Effective size, lane offset and error for the captured request.
  always_comb begin
    w_illegal = (r_size == SZ_DWORD) && (DATA_WIDTH == 32);
    w_ofs_raw = 3'(r_addr[OFS-1:0]);
`ifdef DMEM_ALIGN_CHECK_EN
    w_size_eff = r_size;
    w_ofs3     = w_ofs_raw;
    w_err      = w_illegal || (w_ofs_raw != align_ofs(r_size, w_ofs_raw));
`else
    w_size_eff = w_illegal ? SZ_WORD : r_size;
    w_ofs3     = align_ofs(w_size_eff, w_ofs_raw);
    w_err      = 1'b0;
`endif
    w_idx = r_addr[AW-1:OFS];
  end

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .i_size     (w_size_eff),
    .i_ofs      (w_ofs3[OFS-1:0]),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .i_rword    (r_mem[w_idx]),
    .o_wdata_sh (w_wdata_sh),
    .o_be       (w_be),
    .o_rdata    (w_rdata_ext)
  );

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    w_accept    = 1'b0;
    w_do_access = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (WAIT_STATES > 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES - 1);
          end else begin
            w_state_nxt = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_ACCESS;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      ST_ACCESS: begin
        w_do_access = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control state and registered response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      resp_valid <= 1'b0;
      read_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      resp_valid <= w_do_access;
      if (w_do_access) resp_error <= w_err;
      if (w_do_access && !r_write && !w_err) read_data <= w_rdata_ext;
    end
  end

  // Request capture; inputs are only looked at on accept.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_write <= mem_write;
      r_size  <= mem_size;
      r_uns   <= mem_unsigned;
      r_addr  <= address[AW-1:0];
      r_wdata <= write_data;
    end
  end

  // Lane-masked store into the word array; a reset in ACCESS cancels it.
  always_ff @(posedge clock) begin
    if (w_do_access && r_write && !w_err && !reset) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// Bench for dmem_sized_ctrl: two instances (no wait states and three wait
// states) driven by a request task; expected responses are queued at accept
// and compared by a monitor when resp_valid appears.
// Expectations follow DMEM_ALIGN_CHECK_EN when it is defined.
module tb_dmem_sized_ctrl;

  typedef struct {
    int          acc_cyc;
    int          exp_cyc;
    logic [31:0] rd;
    logic        err;
  } resp_t;

  logic        clock = 1'b0;
  logic        reset        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        mem_write    [2];
  logic [1:0]  mem_size     [2];
  logic        mem_unsigned [2];
  logic [31:0] address      [2];
  logic [31:0] write_data   [2];
  logic        resp_valid   [2];
  logic [31:0] read_data    [2];
  logic        resp_error   [2];

  resp_t       sb [2][$];
  logic [31:0] exp_last [2];
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_sized_ctrl #(.DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .mem_write(mem_write[0]), .mem_size(mem_size[0]), .mem_unsigned(mem_unsigned[0]),
    .address(address[0]), .write_data(write_data[0]), .resp_valid(resp_valid[0]),
    .read_data(read_data[0]), .resp_error(resp_error[0]));

  dmem_sized_ctrl #(.DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(3)) u_dut1 (
    .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .mem_write(mem_write[1]), .mem_size(mem_size[1]), .mem_unsigned(mem_unsigned[1]),
    .address(address[1]), .write_data(write_data[1]), .resp_valid(resp_valid[1]),
    .read_data(read_data[1]), .resp_error(resp_error[1]));

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Response monitor: busy-ready check, then latency/error/data on resp_valid.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (sb[d].size() > 0 && cyc > sb[d][0].acc_cyc && cyc < sb[d][0].exp_cyc)
        check($sformatf("busy_ready%0d", d), req_ready[d], 1'b0);
      if (resp_valid[d] === 1'b1) begin
        if (sb[d].size() == 0) begin
          check($sformatf("spurious_resp%0d", d), 1'b1, 1'b0);
        end else begin
          resp_t it;
          it = sb[d].pop_front();
          check($sformatf("latency%0d", d), 64'(cyc), 64'(it.exp_cyc));
          check($sformatf("resp_error%0d", d), resp_error[d], it.err);
          check($sformatf("read_data%0d", d), read_data[d], it.rd);
        end
      end
    end
  end

  // Issue one request, queue its expected response and wait for it.
  task automatic issue(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] ld_val, input logic err);
    resp_t it;
    int    n;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(posedge clock); #1; n++;
    end
    check($sformatf("ready_idle%0d", d), req_ready[d], 1'b1);
    req_valid[d] = 1'b1; mem_write[d] = wr; mem_size[d] = sz;
    mem_unsigned[d] = uns; address[d] = addr; write_data[d] = wd;
    @(negedge clock);
    it.acc_cyc = cyc;
    it.exp_cyc = cyc + 2 + ws(d);
    it.err     = err;
    if (!wr && !err) exp_last[d] = ld_val;
    it.rd = exp_last[d];
    sb[d].push_back(it);
    @(posedge clock); #1;
    req_valid[d]  = 1'b0;
    mem_write[d]  = 1'($urandom);
    mem_size[d]   = 2'($urandom);
    address[d]    = $urandom;
    write_data[d] = $urandom;
    n = 0;
    while (sb[d].size() != 0 && n < 40) begin
      @(posedge clock); n++;
    end
    if (sb[d].size() != 0) begin
      check($sformatf("resp_timeout%0d", d), 1'b0, 1'b1);
      sb[d].delete();
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; mem_write[d] = 1'b0; mem_size[d] = 2'b00;
      mem_unsigned[d] = 1'b0; address[d] = '0; write_data[d] = '0; exp_last[d] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    reset[0] = 1'b0; reset[1] = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready%0d", d), req_ready[d], 1'b1);
      check($sformatf("rst_resp_valid%0d", d), resp_valid[d], 1'b0);
      check($sformatf("rst_read_data%0d", d), read_data[d], 32'h0);
      check($sformatf("rst_resp_error%0d", d), resp_error[d], 1'b0);
    end
    @(posedge clock); #1;

    // No wait states: word, byte and half traffic.
    issue(0, 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 32'h0, 0);
    issue(0, 0, 2'b10, 1, 32'h8, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 1, 2'b00, 0, 32'h9, 32'h80, 32'h0, 0);
    issue(0, 0, 2'b00, 0, 32'h9, 32'h0, 32'hFFFFFF80, 0);
    issue(0, 0, 2'b00, 1, 32'h9, 32'h0, 32'h00000080, 0);
    issue(0, 0, 2'b10, 0, 32'h8, 32'h0, 32'hDEAD80EF, 0);
    issue(0, 0, 2'b01, 0, 32'hA, 32'h0, 32'hFFFFDEAD, 0);
    issue(0, 0, 2'b01, 1, 32'hA, 32'h0, 32'h0000DEAD, 0);
    issue(0, 1, 2'b10, 0, 32'h4, 32'h0BADCAFE, 32'h0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    issue(0, 0, 2'b10, 0, 32'h6, 32'h0, 32'h0, 1);
    issue(0, 0, 2'b11, 0, 32'h8, 32'h0, 32'h0, 1);
    issue(0, 1, 2'b10, 0, 32'h5, 32'h55, 32'h0, 1);
    issue(0, 0, 2'b10, 0, 32'h4, 32'h0, 32'h0BADCAFE, 0);
`else
    issue(0, 0, 2'b10, 0, 32'h6, 32'h0, 32'h0BADCAFE, 0);
    issue(0, 0, 2'b11, 0, 32'h8, 32'h0, 32'hDEAD80EF, 0);
    issue(0, 1, 2'b10, 0, 32'h5, 32'h55, 32'h0, 0);
    issue(0, 0, 2'b10, 0, 32'h4, 32'h0, 32'h00000055, 0);
`endif
    // Address wrap: 0x80 aliases word 0 with 32 words.
    issue(0, 1, 2'b10, 0, 32'h80, 32'h11, 32'h0, 0);
    issue(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h00000011, 0);

    // Three wait states.
    issue(1, 1, 2'b10, 0, 32'h0, 32'hCAFEF00D, 32'h0, 0);
    issue(1, 1, 2'b01, 0, 32'h2, 32'h1234, 32'h0, 0);
    issue(1, 0, 2'b01, 0, 32'h2, 32'h0, 32'h00001234, 0);
    issue(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h1234F00D, 0);

    // Reset during WAIT drops a store and its response.
    req_valid[1] = 1'b1; mem_write[1] = 1'b1; mem_size[1] = 2'b10;
    mem_unsigned[1] = 1'b0; address[1] = 32'h0; write_data[1] = 32'hFF;
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    reset[1] = 1'b1;
    @(posedge clock); #1;
    reset[1] = 1'b0;
    check("drop_ready1", req_ready[1], 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("drop_no_resp1", resp_valid[1], 1'b0);
    end
    check("drop_read_data1", read_data[1], 32'h0);
    exp_last[1] = 32'h0;
    @(posedge clock); #1;
    issue(1, 0, 2'b10, 0, 32'h0, 32'h0, 32'h1234F00D, 0);

    repeat (4) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
